// File: rtl/hdr_mode_controller_pkg.sv
// Shared I3C target definitions: HDR controller state encoding, o_mode codes
// and the ENTHDR mode index that selects HDR-DDR.
package hdr_mode_controller_pkg;

   typedef enum logic [2:0] {
      ST_SDR       = 3'd0,
      ST_ENTER     = 3'd1,
      ST_DDR       = 3'd2,
      ST_RESTART   = 3'd3,
      ST_IGNORE    = 3'd4,
      ST_EXIT_WAIT = 3'd5
   } hdr_state_e;

   localparam logic [1:0] MODE_SDR    = 2'b00;
   localparam logic [1:0] MODE_DDR    = 2'b01;
   localparam logic [1:0] MODE_IGNORE = 2'b10;
   localparam logic [1:0] MODE_EXIT   = 2'b11;

   localparam logic [2:0] ENTHDR_DDR = 3'b000;

   // ENTER and RESTART are part of the DDR session from the bus's point of view.
   function automatic logic [1:0] mode_of(hdr_state_e s);
      case (s)
         ST_SDR:                        return MODE_SDR;
         ST_ENTER, ST_DDR, ST_RESTART:  return MODE_DDR;
         ST_IGNORE:                     return MODE_IGNORE;
         default:                       return MODE_EXIT;
      endcase
   endfunction

endpackage

// File: rtl/bus_stop_detector.sv
// Flags an SDR STOP: SDA rising while SCL is high in both the previous and
// current sample. The sampler runs in every state.
module bus_stop_detector (
   input  logic i_sys_clk,
   input  logic i_sys_rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_stop
);

   logic scl_q;
   logic sda_q;

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         scl_q <= 1'b0;
         sda_q <= 1'b0;
      end else begin
         scl_q <= i_scl;
         sda_q <= i_sda;
      end
   end

   assign o_stop = scl_q & i_scl & ~sda_q & i_sda;

endmodule

// File: rtl/hdr_mode_controller.sv
// I3C target HDR mode controller: switches the SDR/DDR engines and HDR
// detectors on ENTHDR, restart, exit and STOP events. All outputs registered.
module hdr_mode_controller
   import hdr_mode_controller_pkg::*;
#(
   parameter int STOP_TIMEOUT = 255,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   input  logic       i_enthdr_valid,
   input  logic [2:0] i_enthdr_mode,
   input  logic       i_restart_det,
   input  logic       i_exit_det,
   output logic       o_sdr_engine_en,
   output logic       o_ddr_engine_en,
   output logic       o_restart_det_en,
   output logic       o_exit_det_en,
   output logic [1:0] o_mode,
   output logic       o_restart_pulse,
   output logic       o_exit_pulse,
   output logic       o_err,
   output logic [7:0] o_restart_cnt
);

   localparam int TW = (STOP_TIMEOUT > 1) ? $clog2(STOP_TIMEOUT) : 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   hdr_state_e      state_q, state_d;
   logic [FW-1:0]   flush_q, flush_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            exit_pulse_d, err_d;
   logic            stop;

   logic            sdr_en_q, ddr_en_q, rdet_en_q, edet_en_q;
   logic [1:0]      mode_q;
   logic            restart_pulse_q, exit_pulse_q, err_q;

   bus_stop_detector u_stop (
      .i_sys_clk (i_sys_clk),
      .i_sys_rst (i_sys_rst),
      .i_scl     (i_scl),
      .i_sda     (i_sda),
      .o_stop    (stop)
   );

   always_comb begin
      state_d      = state_q;
      flush_d      = flush_q;
      tmo_d        = tmo_q;
      cnt_d        = cnt_q;
      exit_pulse_d = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_SDR: begin
            if (i_enthdr_valid) begin
               if (i_enthdr_mode == ENTHDR_DDR) begin
                  state_d = ST_ENTER;
                  flush_d = '0;
                  cnt_d   = 8'd0;
               end else begin
                  state_d = ST_IGNORE;
               end
            end
         end
         ST_ENTER: begin
            if (flush_q == FW'(FLUSH_CYCLES - 1)) state_d = ST_DDR;
            else                                  flush_d = flush_q + 1'b1;
         end
         ST_DDR: begin
            // Exit has priority; a coincident restart is dropped entirely.
            if (i_exit_det) begin
               state_d = ST_EXIT_WAIT;
               tmo_d   = '0;
            end else if (i_restart_det) begin
               state_d = ST_RESTART;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RESTART: state_d = ST_DDR;
         ST_IGNORE: begin
            if (i_exit_det) begin
               state_d = ST_EXIT_WAIT;
               tmo_d   = '0;
            end
         end
         ST_EXIT_WAIT: begin
            if (stop) begin
               state_d      = ST_SDR;
               exit_pulse_d = 1'b1;
            end else if (tmo_q == TW'(STOP_TIMEOUT - 1)) begin
               state_d = ST_SDR;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = ST_SDR;
      endcase
   end

   // Outputs decode the next state so they line up with the state register.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_q         <= ST_SDR;
         flush_q         <= '0;
         tmo_q           <= '0;
         cnt_q           <= 8'd0;
         sdr_en_q        <= 1'b1;
         ddr_en_q        <= 1'b0;
         rdet_en_q       <= 1'b0;
         edet_en_q       <= 1'b0;
         mode_q          <= MODE_SDR;
         restart_pulse_q <= 1'b0;
         exit_pulse_q    <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         flush_q         <= flush_d;
         tmo_q           <= tmo_d;
         cnt_q           <= cnt_d;
         sdr_en_q        <= (state_d == ST_SDR);
         ddr_en_q        <= (state_d == ST_DDR);
         rdet_en_q       <= (state_d == ST_DDR);
         edet_en_q       <= (state_d == ST_DDR) || (state_d == ST_IGNORE) ||
                            (state_d == ST_EXIT_WAIT);
         mode_q          <= mode_of(state_d);
         restart_pulse_q <= (state_d == ST_RESTART);
         exit_pulse_q    <= exit_pulse_d;
         err_q           <= err_d;
      end
   end

   assign o_sdr_engine_en  = sdr_en_q;
   assign o_ddr_engine_en  = ddr_en_q;
   assign o_restart_det_en = rdet_en_q;
   assign o_exit_det_en    = edet_en_q;
   assign o_mode           = mode_q;
   assign o_restart_pulse  = restart_pulse_q;
   assign o_exit_pulse     = exit_pulse_q;
   assign o_err            = err_q;
   assign o_restart_cnt    = cnt_q;

endmodule

// File: tb/tb_hdr_mode_controller.sv
// Scoreboard bench for hdr_mode_controller: a behavioural model predicts the
// outputs for every clock, a monitor compares them against the DUT.
module tb_hdr_mode_controller;

   localparam int STOP_TIMEOUT = 255;
   localparam int FLUSH_CYCLES = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1, sda = 1'b1;
   logic       env = 1'b0, rdet = 1'b0, edet = 1'b0;
   logic [2:0] emode = 3'd0;
   logic       sdr_en, ddr_en, rde, ede, rp, ep, err;
   logic [1:0] mode;
   logic [7:0] cnt;

   always #5 clk = ~clk;

   hdr_mode_controller #(.STOP_TIMEOUT(STOP_TIMEOUT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .i_sys_clk        (clk),
      .i_sys_rst        (rst_n),
      .i_scl            (scl),
      .i_sda            (sda),
      .i_enthdr_valid   (env),
      .i_enthdr_mode    (emode),
      .i_restart_det    (rdet),
      .i_exit_det       (edet),
      .o_sdr_engine_en  (sdr_en),
      .o_ddr_engine_en  (ddr_en),
      .o_restart_det_en (rde),
      .o_exit_det_en    (ede),
      .o_mode           (mode),
      .o_restart_pulse  (rp),
      .o_exit_pulse     (ep),
      .o_err            (err),
      .o_restart_cnt    (cnt)
   );

   // Behavioural model: bus phase plus remaining-cycle bookkeeping.
   localparam int P_SDR = 0, P_ENTER = 1, P_DDR = 2, P_RESTART = 3, P_IGNORE = 4, P_EXIT = 5;
   int m_phase, m_left, m_waited, m_cnt;
   bit m_pscl, m_psda, m_rp, m_ep, m_err;

   typedef struct {
      logic [16:0] v;
      string       tag;
   } exp_t;
   exp_t q[$];

   int    n_checks = 0;
   int    n_fail = 0;
   string tag = "reset";
   bit    rst_drive = 1'b0;

   function automatic logic [16:0] dut_vec();
      return {sdr_en, ddr_en, rde, ede, mode, rp, ep, err, cnt};
   endfunction

   function automatic logic [16:0] model_vec();
      logic [1:0] md;
      md = (m_phase == P_SDR) ? 2'd0 : (m_phase == P_IGNORE) ? 2'd2 :
           (m_phase == P_EXIT) ? 2'd3 : 2'd1;
      return {m_phase == P_SDR, m_phase == P_DDR, m_phase == P_DDR,
              (m_phase == P_DDR) || (m_phase == P_IGNORE) || (m_phase == P_EXIT),
              md, m_rp, m_ep, m_err, 8'(m_cnt)};
   endfunction

   task automatic model_reset();
      m_phase = P_SDR; m_left = 0; m_waited = 0; m_cnt = 0;
      m_pscl = 1'b0; m_psda = 1'b0; m_rp = 1'b0; m_ep = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step();
      bit stp;
      stp = m_pscl && scl && !m_psda && sda;
      m_pscl = scl;
      m_psda = sda;
      m_rp = 1'b0; m_ep = 1'b0; m_err = 1'b0;
      case (m_phase)
         P_SDR:
            if (env) begin
               if (emode == 3'b000) begin m_phase = P_ENTER; m_left = FLUSH_CYCLES; m_cnt = 0; end
               else m_phase = P_IGNORE;
            end
         P_ENTER: begin
            m_left--;
            if (m_left == 0) m_phase = P_DDR;
         end
         P_DDR:
            if (edet) begin m_phase = P_EXIT; m_waited = 0; end
            else if (rdet) begin
               m_phase = P_RESTART; m_rp = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         P_RESTART: m_phase = P_DDR;
         P_IGNORE:
            if (edet) begin m_phase = P_EXIT; m_waited = 0; end
         P_EXIT: begin
            m_waited++;
            if (stp) begin m_phase = P_SDR; m_ep = 1'b1; end
            else if (m_waited == STOP_TIMEOUT) begin m_phase = P_SDR; m_err = 1'b1; end
         end
         default: m_phase = P_SDR;
      endcase
   endtask

   // One clock of stimulus; the prediction is for the outputs after the next rising edge.
   task automatic cyc(input bit en, input logic [2:0] md, input bit rd, input bit ed,
                      input bit s_cl, input bit s_da);
      @(negedge clk);
      rst_n = rst_drive;
      env = en; emode = md; rdet = rd; edet = ed; scl = s_cl; sda = s_da;
      if (!rst_n) model_reset();
      else        model_step();
      q.push_back('{v: model_vec(), tag: tag});
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic stop_cond();
      cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: every rising edge that has a pending prediction is compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check({"outputs/", e.tag}, {15'd0, dut_vec()}, {15'd0, e.v});
         end
      end
   end

   initial begin
      model_reset();
      idle(3);
      rst_drive = 1'b1;
      idle(2);

      tag = "enter_ddr";
      cyc(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);

      tag = "restarts";
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
         idle(2);
      end

      tag = "restart_exit_same";
      cyc(1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(2);
      stop_cond();
      idle(2);

      tag = "ignore_mode";
      cyc(1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(2);
      cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(1);
      stop_cond();
      idle(2);

      tag = "timeout";
      cyc(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(STOP_TIMEOUT + 5);

      tag = "saturate";
      cyc(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      for (int i = 0; i < 258; i++) begin
         cyc(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
         idle(1);
      end
      cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      stop_cond();
      idle(1);

      tag = "reset_in_ddr";
      cyc(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
         idle(1);
      end
      @(posedge clk);
      #3;
      check("cnt_before_reset", {24'd0, cnt}, 32'd5);
      rst_drive = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_reset_cnt", {24'd0, cnt}, 32'd0);
      check("async_reset_sdr_en", {31'd0, sdr_en}, 32'd1);
      check("async_reset_ddr_en", {31'd0, ddr_en}, 32'd0);
      idle(3);
      rst_drive = 1'b1;
      idle(3);

      tag = "random";
      for (int i = 0; i < 3000; i++) begin
         bit s_da;
         logic [2:0] md;
         s_da = sda;
         if ($urandom_range(7) == 0) s_da = ~s_da;
         md = ($urandom_range(2) == 0) ? 3'd0 : 3'($urandom_range(7));
         cyc($urandom_range(15) == 0, md, $urandom_range(5) == 0, $urandom_range(19) == 0,
             $urandom_range(9) != 0, s_da);
      end
      idle(3);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
